// File: rtl/float_enc_pkg.sv
// Shared types and default constants for the linear-to-float encoder.
package float_enc_pkg;

  localparam int unsigned DEF_IN_W  = 12;
  localparam int unsigned DEF_SIG_W = 4;
  localparam int unsigned DEF_EXP_W = 3;

  // Largest exponent, also the starting exponent before normalisation.
  localparam int unsigned E_MAX      = 2**DEF_EXP_W - 1;
  // Bits below the significand, i.e. rounding and sticky bits plus the sign slot.
  localparam int unsigned SHIFT_BASE = DEF_IN_W - DEF_SIG_W;

  typedef enum logic [2:0] {
    StIdle,
    StAbs,
    StNorm,
    StRound,
    StDone
  } state_e;

endpackage

// File: rtl/float_encoder_if.sv
// Sample-in / float-out handshake bundle for float_encoder.
// master: the side feeding samples and consuming results; slave: the encoder.
interface float_encoder_if #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned SIG_W = 4,
  parameter int unsigned EXP_W = 3
);

  logic [IN_W-1:0]  D;
  logic             in_valid;
  logic             in_ready;
  logic             S;
  logic [EXP_W-1:0] E;
  logic [SIG_W-1:0] F;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output D, in_valid, out_ready,
    input  in_ready, S, E, F, out_valid
  );

  modport slave (
    input  D, in_valid, out_ready,
    output in_ready, S, E, F, out_valid
  );

endinterface

// File: rtl/float_round.sv
// Combinational rounding step: rounds the normalised significand and handles
// carry-out into the exponent, saturating at the largest exponent.
// Build option: FLOAT_ENCODER_RNE_EN selects round-half-to-even instead of
// round-half-up.
module float_round #(
  parameter int unsigned SIG_W = 4,
  parameter int unsigned EXP_W = 3
) (
  input  logic [SIG_W-1:0] F0,
  input  logic [EXP_W-1:0] exp,
  input  logic             fifth,
  input  logic             sticky,
  output logic [EXP_W-1:0] E,
  output logic [SIG_W-1:0] F
);

  localparam logic [EXP_W-1:0] EMax = '1;

  logic inc;

`ifdef FLOAT_ENCODER_RNE_EN
  assign inc = fifth & (sticky | F0[0]);
`else
  // Half-up ignores the sticky bit; the top ties it low.
  logic unused_sticky;
  assign unused_sticky = sticky;
  assign inc = fifth;
`endif

  // Denormals (exp == 0) pass through unrounded.
  always_comb begin
    E = exp;
    F = F0;
    if (exp != '0 && inc) begin
      if (&F0) begin
        if (exp == EMax) begin
          E = '1;
          F = '1;
        end else begin
          E = exp + 1'b1;
          F = {1'b1, {(SIG_W-1){1'b0}}};
        end
      end else begin
        F = F0 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/float_encoder.sv
// Two's-complement linear sample to sign/exponent/significand encoder.
// One sample in flight: capture, magnitude, normalise (one shift per cycle),
// round, then hold the result until the consumer takes it.
// Build option: FLOAT_ENCODER_RNE_EN enables round-half-to-even.
module float_encoder
  import float_enc_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned SIG_W = DEF_SIG_W,
  parameter int unsigned EXP_W = DEF_EXP_W
) (
  input  logic            clk,
  input  logic            rst,
  float_encoder_if.slave  bus
);

  localparam logic [EXP_W-1:0] EMax      = '1;
  localparam int unsigned      ShiftBase = IN_W - SIG_W;

  if (IN_W != SIG_W + 2**EXP_W) begin : g_bad_params
    $error("float_encoder: IN_W must equal SIG_W + 2**EXP_W");
  end

  state_e state_q, state_d;

  logic [IN_W-1:0]  d_q;
  logic [IN_W-2:0]  mag_q, mag_abs;
  logic [EXP_W-1:0] exp_q, round_e;
  logic [SIG_W-1:0] round_f, f0;
  logic [EXP_W-1:0] e_q;
  logic [SIG_W-1:0] f_q;
  logic             s_q, out_valid_q;
  logic             accept, shift, fifth, sticky;
  logic [IN_W-1:0]  d_neg;

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.S         = s_q;
  assign bus.E         = e_q;
  assign bus.F         = f_q;
  assign bus.out_valid = out_valid_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign shift  = !mag_q[IN_W-2] && (exp_q != '0);

  // Most-negative input has no positive twin; clamp it to the largest magnitude.
  assign d_neg = ~d_q + 1'b1;
  always_comb begin
    mag_abs = d_q[IN_W-2:0];
    if (d_q[IN_W-1]) begin
      if (d_q[IN_W-2:0] == '0) mag_abs = '1;
      else                     mag_abs = d_neg[IN_W-2:0];
    end
  end

  assign f0    = mag_q[IN_W-2 -: SIG_W];
  assign fifth = mag_q[ShiftBase-2];
`ifdef FLOAT_ENCODER_RNE_EN
  assign sticky = |mag_q[ShiftBase-3:0];
`else
  assign sticky = 1'b0;
`endif

  float_round #(
    .SIG_W (SIG_W),
    .EXP_W (EXP_W)
  ) u_round (
    .F0     (f0),
    .exp    (exp_q),
    .fifth  (fifth),
    .sticky (sticky),
    .E      (round_e),
    .F      (round_f)
  );

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StAbs;
      StAbs:   state_d = StNorm;
      StNorm:  if (!shift) state_d = StRound;
      StRound: state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Datapath and output registers, advanced by the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q         <= '0;
      mag_q       <= '0;
      exp_q       <= '0;
      s_q         <= 1'b0;
      e_q         <= '0;
      f_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (accept) d_q <= bus.D;
        StAbs: begin
          s_q   <= d_q[IN_W-1];
          mag_q <= mag_abs;
          exp_q <= EMax;
        end
        StNorm: if (shift) begin
          mag_q <= {mag_q[IN_W-3:0], 1'b0};
          exp_q <= exp_q - 1'b1;
        end
        StRound: begin
          e_q         <= round_e;
          f_q         <= round_f;
          out_valid_q <= 1'b1;
        end
        StDone: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_encoder.sv
// Directed bench for float_encoder: vector table plus handshake/reset corners.
module tb_float_encoder;

  logic clk = 1'b0;
  logic rst;

  float_encoder_if #(.IN_W(12), .SIG_W(4), .EXP_W(3)) bus ();

  float_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] d;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  f;
    int          k;
  } vec_t;

  vec_t vecs[12];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present a sample and return just after the accepting edge.
  task automatic send(input logic [11:0] d);
    int g;
    @(negedge clk);
    bus.D        = d;
    bus.in_valid = 1'b1;
    g = 0;
    while (!bus.in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges after the accept until out_valid is seen (bounded).
  task automatic wait_out(output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) break;
    end
  endtask

  task automatic watch_quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int          lat;
    logic [3:0]  f17;
    logic        hs;
    logic [2:0]  he;
    logic [3:0]  hf;

`ifdef FLOAT_ENCODER_RNE_EN
    f17 = 4'b1000;
`else
    f17 = 4'b1001;
`endif
    vecs[0]  = '{12'd422,  1'b0, 3'd5, 4'b1101, 2};
    vecs[1]  = '{12'd125,  1'b0, 3'd4, 4'b1000, 4};
    vecs[2]  = '{12'h800,  1'b1, 3'd7, 4'b1111, 0};
    vecs[3]  = '{12'hFF9,  1'b1, 3'd0, 4'b0111, 7};
    vecs[4]  = '{12'd17,   1'b0, 3'd1, f17,     6};
    vecs[5]  = '{12'd0,    1'b0, 3'd0, 4'b0000, 7};
    vecs[6]  = '{12'd1023, 1'b0, 3'd7, 4'b1000, 1};
    vecs[7]  = '{12'd2047, 1'b0, 3'd7, 4'b1111, 0};
    vecs[8]  = '{12'hE5A,  1'b1, 3'd5, 4'b1101, 2};
    vecs[9]  = '{12'd1024, 1'b0, 3'd7, 4'b1000, 0};
    vecs[10] = '{12'd72,   1'b0, 3'd3, 4'b1001, 4};
    vecs[11] = '{12'd35,   1'b0, 3'd2, 4'b1001, 5};

    rst           = 1'b1;
    bus.D         = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_sef", {bus.S, bus.E, bus.F}, 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);

    // Table: consumer always ready.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].d);
      wait_out(lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].k + 3);
      check($sformatf("v%0d_S", i), bus.S, vecs[i].s);
      check($sformatf("v%0d_E", i), bus.E, vecs[i].e);
      check($sformatf("v%0d_F", i), bus.F, vecs[i].f);
      @(negedge clk);
      check($sformatf("v%0d_back_idle", i), {bus.out_valid, bus.in_ready}, 2'b01);
    end

    // Back-pressure: result held, a pulse on in_valid is ignored.
    bus.out_ready = 1'b0;
    send(12'd422);
    wait_out(lat);
    check("hold_latency", lat, 5);
    hs = bus.S;
    he = bus.E;
    hf = bus.F;
    check("hold_first_F", hf, 4'b1101);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.D        = 12'd17;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      check($sformatf("hold%0d", i),
            {bus.out_valid, bus.in_ready, bus.S, bus.E, bus.F},
            {1'b1, 1'b0, hs, he, hf});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_idle", {bus.out_valid, bus.in_ready}, 2'b01);
    watch_quiet("hold_pulse_not_captured", 15);

    // Reset mid-normalisation aborts the sample.
    send(12'hFF9);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_norm_out_valid", bus.out_valid, 0);
    check("rst_norm_sef", {bus.S, bus.E, bus.F}, 0);
    rst = 1'b0;
    #1;
    check("rst_norm_in_ready", bus.in_ready, 1);
    watch_quiet("rst_norm_no_output", 15);

    // Reset while a result is stalled in DONE.
    bus.out_ready = 1'b0;
    send(12'd125);
    wait_out(lat);
    check("rst_done_pre_F", bus.F, 4'b1000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_done_cleared", {bus.out_valid, bus.S, bus.E, bus.F}, 0);
    check("rst_done_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    watch_quiet("rst_done_no_output", 12);

    // Recovery after aborts.
    send(12'd125);
    wait_out(lat);
    check("recover_latency", lat, 7);
    check("recover_EF", {bus.E, bus.F}, {3'd4, 4'b1000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/float_encoder.md
FLOAT_ENCODER -- requirements
Module: float_encoder

Interface
REQ-001 Parameter IN_W, default 12, width of the two's-complement linear input.
REQ-002 Parameter SIG_W, default 4, significand width.
REQ-003 Parameter EXP_W, default 3, exponent width; legal only when IN_W == SIG_W + 2**EXP_W (elaboration error otherwise).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 D  input  IN_W  two's-complement sample.
REQ-007 in_valid  input  1  D is valid.
REQ-008 in_ready  output  1  block can accept a sample.
REQ-009 S  output  1  sign.
REQ-010 E  output  EXP_W  exponent.
REQ-011 F  output  SIG_W  significand.
REQ-012 out_valid  output  1  S/E/F are valid.
REQ-013 out_ready  input  1  consumer accepts S/E/F.

Function
REQ-014 FSM states: IDLE, ABS, NORM, ROUND, DONE; single sample in flight, no overlap.
REQ-015 in_ready shall equal (state == IDLE && !rst); an accept (in_valid && in_ready) shall capture D and move to ABS.
REQ-016 ABS shall set S = D[IN_W-1] and mag = |D|; D == -2**(IN_W-1) shall saturate mag to 2**(IN_W-1)-1.
REQ-017 NORM shall start with exp = 2**EXP_W-1; each cycle in which mag[IN_W-2]==0 and exp>0, it shall shift mag left by 1 and decrement exp; otherwise it shall go to ROUND.
REQ-018 NORM occupies k+1 cycles for k shifts (k in 0..2**EXP_W-1).
REQ-019 ROUND: F0 = mag[IN_W-2 -: SIG_W], fifth = next lower bit, sticky = OR of all remaining lower bits; when exp==0, no rounding is applied and F = F0.
REQ-020 Round-half-up (default): if fifth, add 1 to F0; on carry out, F = 1000..0 and E = exp+1.
REQ-021 Saturation: when exp == 2**EXP_W-1 and the increment carries out, E and F shall be all ones.
REQ-022 DONE shall assert out_valid and hold S/E/F stable until out_valid && out_ready, then return to IDLE in the next cycle.
REQ-023 Latency from the accept cycle to the first out_valid cycle shall be k+3 cycles.
REQ-024 in_valid is ignored outside IDLE; out_ready is ignored outside DONE.

Reset
REQ-025 When rst is high at an edge: state = IDLE, out_valid = 0, S = 0, E = 0, F = 0, internal mag/exp cleared.
REQ-026 Reset in any state, including mid-NORM or DONE with out_ready low, shall abort the in-flight sample without emitting it.

Configuration
REQ-027 With FLOAT_ENCODER_RNE_EN defined, ROUND shall use round-half-to-even: increment only if fifth && (sticky || F0[0]).
REQ-028 Without FLOAT_ENCODER_RNE_EN, round-half-up per REQ-020 applies and sticky logic shall not be synthesised.

Structure
REQ-029 Package float_enc_pkg shall hold the FSM state enum and constants E_MAX = 2**EXP_W-1 and SHIFT_BASE = IN_W-SIG_W.
REQ-030 The rounding step shall be a combinational sub-module, float_round (inputs F0, exp, fifth, sticky; outputs E, F).

Verification (IN_W=12, SIG_W=4, EXP_W=3)
REQ-031 D=12'd422 -> S=0, E=5, F=4'b1101; k=2; out_valid asserted 5 cycles after the accept.
REQ-032 D=12'd125 -> fifth=1 causes a carry -> S=0, E=4, F=4'b1000.
REQ-033 D=12'h800 -> S=1, E=7, F=4'b1111 (magnitude saturation plus rounding saturation); D=12'hFF9 -> S=1, E=0, F=4'b0111.
REQ-034 D=12'd17 -> E=1, F=4'b1001 by default; with FLOAT_ENCODER_RNE_EN, F=4'b1000.
REQ-035 Hold out_ready low for 10 cycles in DONE -> S/E/F/out_valid stable and in_ready=0; a D pulsed meanwhile is not captured; then out_ready=1 -> IDLE in the next cycle.
REQ-036 Assert rst during NORM -> next cycle in IDLE, out_valid=0, outputs zero, and no output is produced for the aborted sample.
